// File: rtl/quad_mux_sequencer_pkg.sv
// Shared types and sizing helpers for the quad mux sequencer.
// Build option: QMS_AUTO_REPEAT_EN (see quad_mux_sequencer.sv).
package quad_mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int DWELL_DEF  = 4;
    localparam int DWELL_W    = $clog2(DWELL_DEF + 1);
    localparam int GAP_CYCLES = 1;

    function automatic int dwell_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/quad_mux_sequencer_if.sv
// Producer handshake plus mux-side bundle for the quad mux sequencer.
// master = producer / observer, slave = sequencer.
interface quad_mux_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             abort;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic             mux_s;
    logic             mux_e;
    logic             busy;
    logic             pair_done;

    modport master (
        output in_valid, in_a, in_b, abort,
        input  in_ready, mux_a, mux_b, mux_s, mux_e,
        input  busy, pair_done
    );

    modport slave (
        input  in_valid, in_a, in_b, abort,
        output in_ready, mux_a, mux_b, mux_s, mux_e,
        output busy, pair_done
    );

endinterface

// File: rtl/quad_mux_sequencer_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the final cycle.
// Build option: none.
module qms_dwell_counter
    import quad_mux_seq_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int W     = dwell_w(DWELL)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [W-1:0] cnt;

    assign last = (cnt == W'(DWELL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_mux_sequencer.sv
// Sequences held A/B nibbles onto a quad 2:1 mux: A dwell, B dwell, 1-cycle gap.
// Build option: QMS_AUTO_REPEAT_EN repeats the held pair instead of idling.
module quad_mux_sequencer
    import quad_mux_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DWELL = 4
) (
    input logic              clk,
    input logic              rst_n,
    quad_mux_sequencer_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             s_q;
    logic             e_q;
    logic             pd_q;
    logic             show;
    logic             last;
    logic             rdy;
    logic             hs;
    logic             cnt_clear;

    assign show      = (state == SHOW_A) || (state == SHOW_B);
    assign rdy       = ((state == IDLE) || (state == GAP)) && !bus.abort;
    assign hs        = bus.in_valid && rdy;
    assign cnt_clear = bus.abort || !show || last;

    qms_dwell_counter #(
        .DWELL (DWELL),
        .W     (dwell_w(DWELL))
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (show),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= 1'b0;
            e_q   <= 1'b1;
            pd_q  <= 1'b0;
        end else begin
            pd_q <= 1'b0;
            if (bus.abort) begin
                state <= IDLE;
                s_q   <= 1'b0;
                e_q   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (hs) begin
                            a_q   <= bus.in_a;
                            b_q   <= bus.in_b;
                            state <= SHOW_A;
                            s_q   <= 1'b0;
                            e_q   <= 1'b0;
                        end
                    end
                    SHOW_A: begin
                        // A->B flips select only; enable stays low
                        if (last) begin
                            state <= SHOW_B;
                            s_q   <= 1'b1;
                        end
                    end
                    SHOW_B: begin
                        if (last) begin
                            state <= GAP;
                            e_q   <= 1'b1;
                            pd_q  <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (hs) begin
                            a_q   <= bus.in_a;
                            b_q   <= bus.in_b;
                            state <= SHOW_A;
                            s_q   <= 1'b0;
                            e_q   <= 1'b0;
                        end else begin
`ifdef QMS_AUTO_REPEAT_EN
                            state <= SHOW_A;
                            s_q   <= 1'b0;
                            e_q   <= 1'b0;
`else
                            state <= IDLE;
                            s_q   <= 1'b0;
                            e_q   <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                        s_q   <= 1'b0;
                        e_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.mux_a     = a_q;
    assign bus.mux_b     = b_q;
    assign bus.mux_s     = s_q;
    assign bus.mux_e     = e_q;
    assign bus.busy      = (state != IDLE);
    assign bus.pair_done = pd_q;

endmodule
